// File: rtl/pc_redirect.sv
// pc_redirect: fetch PC register, instruction-memory request handshake and redirect/flush control.
// Optional misaligned-target trap enabled by defining PC_REDIRECT_MISALIGN_TRAP_EN.
`default_nettype none

module pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic        ex_is_jump,
    input  logic        br_taken,
    input  logic [31:0] ex_target,
    input  logic        stall,
    input  logic        if_ready,
    output logic        if_req,
    output logic [31:0] pc_o,
    output logic        flush,
    output logic [31:0] redirect_cnt,
    output logic        trap_o,
    output logic [31:0] trap_pc
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
    localparam logic [1:0] ST_TRAP = 2'd2;
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic        if_req_q, if_req_d;

    logic        redirect_w;
    logic [31:0] target_w;
    logic        unused_target_lsb;

    assign redirect_w        = ex_valid & (ex_is_jump | (ex_is_br & br_taken));
    assign unused_target_lsb = ex_target[0];

`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
    logic [31:0] trap_pc_q, trap_pc_d;
    logic        misalign_w;

    assign target_w   = {ex_target[31:1], 1'b0};
    assign misalign_w = target_w[1];
    assign trap_o     = (state_q == ST_TRAP);
    assign trap_pc    = trap_pc_q;
`else
    // Without the trap, redirects are silently forced onto a word boundary.
    assign target_w = {ex_target[31:2], 2'b00};
    assign trap_o   = 1'b0;
    assign trap_pc  = 32'h0000_0000;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        cnt_d     = cnt_q;
        if_req_d  = 1'b1;
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
        trap_pc_d = trap_pc_q;
`endif
        case (state_q)
            ST_RUN: begin
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
                if (redirect_w && misalign_w) begin
                    state_d   = ST_TRAP;
                    trap_pc_d = target_w;
                    if_req_d  = 1'b0;
                end else
`endif
                if (redirect_w) begin
                    cnt_d = cnt_q + 32'd1;
                    // An outstanding unaccepted request must keep its address stable.
                    if (if_ready || !if_req_q) begin
                        pc_d = target_w;
                    end else begin
                        pend_pc_d = target_w;
                        state_d   = ST_HOLD;
                    end
                end else if (if_req_q && if_ready && !stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_HOLD: begin
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
                if (redirect_w && misalign_w) begin
                    state_d   = ST_TRAP;
                    trap_pc_d = target_w;
                    if_req_d  = 1'b0;
                end else
`endif
                begin
                    if (redirect_w) begin
                        cnt_d     = cnt_q + 32'd1;
                        pend_pc_d = target_w;
                    end
                    if (if_ready) begin
                        pc_d    = redirect_w ? target_w : pend_pc_q;
                        state_d = ST_RUN;
                    end
                end
            end
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
            ST_TRAP: begin
                if_req_d = 1'b0;
            end
`endif
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'h0000_0000;
            cnt_q     <= 32'h0000_0000;
            if_req_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
            if_req_q  <= if_req_d;
        end
    end

`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_pc_q <= 32'h0000_0000;
        end else begin
            trap_pc_q <= trap_pc_d;
        end
    end
`endif

    assign if_req       = if_req_q;
    assign pc_o         = pc_q;
    assign redirect_cnt = cnt_q;
    assign flush        = !rst & (redirect_w | (state_q == ST_HOLD));

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect.sv
// Scoreboard bench for pc_redirect: driver queues per-cycle expectations, monitor compares at negedge.
`default_nettype none

module tb_pc_redirect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_is_br = 1'b0;
    logic        ex_is_jump = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] ex_target = 32'h0;
    logic        stall = 1'b0;
    logic        if_ready = 1'b0;
    logic        if_req;
    logic [31:0] pc_o;
    logic        flush;
    logic [31:0] redirect_cnt;
    logic        trap_o;
    logic [31:0] trap_pc;

    pc_redirect #(.RESET_PC(32'h0000_0100)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_is_br     (ex_is_br),
        .ex_is_jump   (ex_is_jump),
        .br_taken     (br_taken),
        .ex_target    (ex_target),
        .stall        (stall),
        .if_ready     (if_ready),
        .if_req       (if_req),
        .pc_o         (pc_o),
        .flush        (flush),
        .redirect_cnt (redirect_cnt),
        .trap_o       (trap_o),
        .trap_pc      (trap_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        fl;
        logic        rq;
        logic [31:0] cnt;
        logic        tr;
        logic [31:0] tpc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle; compare away from the rising edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.name, "pc_o",         pc_o,                 e.pc);
                chk(e.name, "flush",        {31'h0, flush},       {31'h0, e.fl});
                chk(e.name, "if_req",       {31'h0, if_req},      {31'h0, e.rq});
                chk(e.name, "redirect_cnt", redirect_cnt,         e.cnt);
                chk(e.name, "trap_o",       {31'h0, trap_o},      {31'h0, e.tr});
                chk(e.name, "trap_pc",      trap_pc,              e.tpc);
            end
        end
    end

    task automatic cyc(input string n, input bit r, input bit v, input bit br, input bit jp,
                       input bit tk, input logic [31:0] tgt, input bit st, input bit rdy,
                       input logic [31:0] epc, input bit ef, input bit erq, input logic [31:0] ecnt,
                       input bit etr = 1'b0, input logic [31:0] etpc = 32'h0, input bit preset = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = r;
        ex_valid   = v;
        ex_is_br   = br;
        ex_is_jump = jp;
        br_taken   = tk;
        ex_target  = tgt;
        stall      = st;
        if_ready   = rdy;
        if (preset) begin
            force dut.cnt_q = 32'hFFFF_FFFF;
            #1;
            release dut.cnt_q;
        end
        e.name = n; e.pc = epc; e.fl = ef; e.rq = erq; e.cnt = ecnt; e.tr = etr; e.tpc = etpc;
        exp_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //   name           rst v br jp tk target        st rdy  pc            fl rq cnt
        cyc("rst_flushgate", 1, 1, 0, 1, 0, 32'h80,       0, 1, 32'h100,       0, 0, 32'd0);
        cyc("rst_release",   0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h100,       0, 0, 32'd0);
        cyc("seq0",          0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h100,       0, 1, 32'd0);
        cyc("seq1",          0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h104,       0, 1, 32'd0);
        cyc("br_taken",      0, 1, 1, 0, 1, 32'h200,      0, 1, 32'h108,       1, 1, 32'd0);
        cyc("br_target",     0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h200,       0, 1, 32'd1);
        cyc("br_not_taken",  0, 1, 1, 0, 0, 32'h500,      0, 1, 32'h204,       0, 1, 32'd1);
        cyc("nt_seq",        0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h208,       0, 1, 32'd1);
        cyc("jal_stall",     0, 1, 0, 1, 0, 32'h40,       1, 1, 32'h20C,       1, 1, 32'd1);
        cyc("stall_tgt",     0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h40,        0, 1, 32'd2);
        cyc("stall_hold",    0, 0, 0, 0, 0, 32'h0,        1, 1, 32'h40,        0, 1, 32'd2);
        cyc("stall_fall",    0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h40,        0, 1, 32'd2);
        cyc("post_stall",    0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h44,        0, 1, 32'd2);
        cyc("hold_enter",    0, 1, 0, 1, 0, 32'h80,       0, 0, 32'h48,        1, 1, 32'd2);
        cyc("hold_1",        0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h48,        1, 1, 32'd3);
        cyc("hold_2",        0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h48,        1, 1, 32'd3);
        cyc("hold_ready",    0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h48,        1, 1, 32'd3);
        cyc("hold_exit",     0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h80,        0, 1, 32'd3);
        cyc("hold2_enter",   0, 1, 0, 1, 0, 32'h80,       0, 0, 32'h84,        1, 1, 32'd3);
        cyc("hold2_retgt",   0, 1, 0, 1, 0, 32'hC0,       0, 0, 32'h84,        1, 1, 32'd4);
        cyc("hold2_ready",   0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h84,        1, 1, 32'd5);
        cyc("hold2_last",    0, 0, 0, 0, 0, 32'h0,        0, 1, 32'hC0,        0, 1, 32'd5);
        cyc("jalr_odd",      0, 1, 0, 1, 0, 32'h301,      0, 1, 32'hC4,        1, 1, 32'd5);
        cyc("jalr_align",    0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h300,       0, 1, 32'd6);
        cyc("jmp_top",       0, 1, 0, 1, 0, 32'hFFFF_FFFC,0, 1, 32'h304,       1, 1, 32'd6);
        cyc("pc_top",        0, 0, 0, 0, 0, 32'h0,        0, 1, 32'hFFFF_FFFC, 0, 1, 32'd7);
        cyc("pc_wrap",       0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,         0, 1, 32'd7);
        cyc("cnt_preset",    0, 1, 0, 1, 0, 32'h10,       0, 1, 32'h4,         1, 1, 32'hFFFF_FFFF, 0, 0, 1);
        cyc("cnt_wrap",      0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h10,        0, 1, 32'd0);
        cyc("jmp_302",       0, 1, 0, 1, 0, 32'h302,      0, 1, 32'h14,        1, 1, 32'd0);
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
        cyc("trap_enter",    0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h14,        0, 0, 32'd0, 1, 32'h302);
        cyc("trap_stay",     0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h14,        0, 0, 32'd0, 1, 32'h302);
`else
        cyc("align_302",     0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h300,       0, 1, 32'd1);
        cyc("align_seq",     0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h304,       0, 1, 32'd1);
`endif
        cyc("rst_again",     1, 0, 0, 0, 0, 32'h0,        0, 1, 32'h100,       0, 0, 32'd0);
        cyc("rst_rel2",      0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h100,       0, 0, 32'd0);
        cyc("req_up",        0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h100,       0, 1, 32'd0);
        cyc("hold3_enter",   0, 1, 0, 1, 0, 32'h80,       0, 0, 32'h104,       1, 1, 32'd0);
        cyc("hold3_wait",    0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h104,       1, 1, 32'd1);
        cyc("rst_mid_hold",  1, 1, 0, 1, 0, 32'h80,       0, 0, 32'h100,       0, 0, 32'd0);
        cyc("rst_rel3",      0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h100,       0, 0, 32'd0);
        cyc("run_after",     0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h100,       0, 1, 32'd0);
        cyc("seq_after",     0, 0, 0, 0, 0, 32'h0,        0, 1, 32'h104,       0, 1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        chk("scoreboard", "pending", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
